mips_decode_stage: RTL and testbench

//  ID stage of the MIPS-Lite 5-stage pipeline. Sits between fetch (IF) and execute (EX).

---
 rtl/mips_decode_stage_pkg.sv | 66 ++++++
 rtl/mips_decode_stage_if.sv | 11 +
 rtl/mips_regfile.sv | 31 +++
 rtl/mips_decode_stage.sv | 138 +++++++++++++
 tb/tb_mips_decode_stage.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_decode_stage_pkg.sv
// Shared MIPS-Lite decode definitions: opcode constants, opcode classes and the
// decoded instruction record used to fill the ID/EX payload.
package mips_decode_stage_pkg;

   localparam logic [5:0] OP_ADD  = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h01;
   localparam logic [5:0] OP_SUB  = 6'h02;
   localparam logic [5:0] OP_SUBI = 6'h03;
   localparam logic [5:0] OP_MUL  = 6'h04;
   localparam logic [5:0] OP_MULI = 6'h05;
   localparam logic [5:0] OP_OR   = 6'h06;
   localparam logic [5:0] OP_ORI  = 6'h07;
   localparam logic [5:0] OP_AND  = 6'h08;
   localparam logic [5:0] OP_ANDI = 6'h09;
   localparam logic [5:0] OP_XOR  = 6'h0A;
   localparam logic [5:0] OP_XORI = 6'h0B;
   localparam logic [5:0] OP_LDW  = 6'h0C;
   localparam logic [5:0] OP_STW  = 6'h0D;
   localparam logic [5:0] OP_BZ   = 6'h0E;
   localparam logic [5:0] OP_BEQ  = 6'h0F;
   localparam logic [5:0] OP_JR   = 6'h10;
   localparam logic [5:0] OP_HALT = 6'h11;

   typedef enum logic [2:0] {
      CLS_NOP,
      CLS_ALU,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_HALT
   } op_class_e;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  src1;
      logic [4:0]  src2;
      logic [4:0]  dest;
      logic [31:0] imm;
      op_class_e   op_class;
      logic        uses_rt;
   } instruction_set;

   // Even opcodes up to XOR are R-type (dest = rd); everything else uses rt as dest.
   function automatic instruction_set decode(input logic [31:0] instr);
      instruction_set d;
      logic           r_type;
      d.opcode = instr[31:26];
      r_type   = (d.opcode <= OP_XOR) && !d.opcode[0];
      d.src1   = instr[25:21];
      d.src2   = instr[20:16];
      d.dest   = r_type ? instr[15:11] : instr[20:16];
      d.imm    = {{16{instr[15]}}, instr[15:0]};
      case (d.opcode)
         OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_MULI,
         OP_OR, OP_ORI, OP_AND, OP_ANDI, OP_XOR, OP_XORI: d.op_class = CLS_ALU;
         OP_LDW:                                         d.op_class = CLS_LOAD;
         OP_STW:                                         d.op_class = CLS_STORE;
         OP_BZ, OP_BEQ, OP_JR:                           d.op_class = CLS_BRANCH;
         OP_HALT:                                        d.op_class = CLS_HALT;
         default:                                        d.op_class = CLS_NOP;
      endcase
      d.uses_rt = r_type || (d.opcode == OP_STW) || (d.opcode == OP_BEQ);
      return d;
   endfunction

endpackage

// File: rtl/mips_decode_stage_if.sv
// Fetch-to-decode handshake. A word transfers on a rising edge where if_valid and
// if_ready are both 1; while if_ready is 0 fetch holds if_instr/if_pc stable.
interface mips_decode_stage_if;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_ready;

   modport master (output if_valid, if_instr, if_pc, input if_ready);
   modport slave  (input if_valid, if_instr, if_pc, output if_ready);
endinterface

// File: rtl/mips_regfile.sv
// 2-read 1-write register file; R0 is hard zero, reads of the register being
// written this cycle return the write data.
module mips_regfile #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [4:0]      ra1,
   input  logic [4:0]      ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [4:0]      wa,
   input  logic [XLEN-1:0] wd
);

   logic [XLEN-1:0] regs [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && (wa != 5'd0)) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? '0 : (we && (wa == ra1)) ? wd : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : (we && (wa == ra2)) ? wd : regs[ra2];

endmodule

// File: rtl/mips_decode_stage.sv
// MIPS-Lite ID stage: IF/ID register, decode, register read, RAW hazard stall,
// branch flush, HALT latch and the registered ID/EX payload.
module mips_decode_stage
   import mips_decode_stage_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int NREG       = 32,
   parameter int FORWARDING = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mips_decode_stage_if.slave   fetch,
   input  logic                 flush,
   input  logic                 ex_valid,
   input  logic [4:0]           ex_dest,
   input  logic                 ex_is_load,
   input  logic                 mem_valid,
   input  logic [4:0]           mem_dest,
   input  logic                 wb_we,
   input  logic [4:0]           wb_dest,
   input  logic [XLEN-1:0]      wb_data,
   output logic                 id_valid,
   output logic [5:0]           id_opcode,
   output logic [4:0]           id_src1,
   output logic [4:0]           id_src2,
   output logic [4:0]           id_dest,
   output logic [XLEN-1:0]      id_rs_val,
   output logic [XLEN-1:0]      id_rt_val,
   output logic [XLEN-1:0]      id_imm,
   output logic [31:0]          id_pc,
   output logic                 id_writes_reg,
   output logic                 id_is_load,
   output logic                 id_is_store,
   output logic                 id_is_branch,
   output logic                 id_is_halt,
   output logic                 halted
);

   logic            ifid_valid;
   logic [31:0]     ifid_instr;
   logic [31:0]     ifid_pc;
   instruction_set  dec;
   logic [XLEN-1:0] rs_val;
   logic [XLEN-1:0] rt_val;
   logic            stall;
   logic            halting_now;
   logic            issue;

   assign dec = decode(ifid_instr);

   mips_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .ra1   (dec.src1),
      .ra2   (dec.src2),
      .rd1   (rs_val),
      .rd2   (rt_val),
      .we    (wb_we),
      .wa    (wb_dest),
      .wd    (wb_data)
   );

   function automatic logic raw_hit(input logic v, input logic [4:0] d,
                                    input instruction_set i);
      return v && (d != 5'd0) && ((d == i.src1) || ((d == i.src2) && i.uses_rt));
   endfunction

   // With forwarding only a load in EX cannot be bypassed in time.
   always_comb begin
      if (FORWARDING != 0)
         stall = ifid_valid && raw_hit(ex_valid && ex_is_load, ex_dest, dec);
      else
         stall = ifid_valid && (raw_hit(ex_valid, ex_dest, dec) ||
                                raw_hit(mem_valid, mem_dest, dec));
   end

   // HALT moving into ID/EX closes the front door in the same cycle so nothing
   // behind it is ever captured.
   assign halting_now    = ifid_valid && (dec.op_class == CLS_HALT) && !stall && !flush;
   assign issue          = ifid_valid && !stall && !flush;
   assign fetch.if_ready = !halted && !halting_now && (flush || !stall);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_valid <= 1'b0;
         ifid_instr <= '0;
         ifid_pc    <= '0;
      end else if (flush || halted || halting_now) begin
         ifid_valid <= 1'b0;
      end else if (!stall) begin
         ifid_valid <= fetch.if_valid;
         if (fetch.if_valid) begin
            ifid_instr <= fetch.if_instr;
            ifid_pc    <= fetch.if_pc;
         end
      end
   end

   // Bubbles clear only valid and the class flags; data fields keep their last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_valid      <= 1'b0;
         id_opcode     <= '0;
         id_src1       <= '0;
         id_src2       <= '0;
         id_dest       <= '0;
         id_rs_val     <= '0;
         id_rt_val     <= '0;
         id_imm        <= '0;
         id_pc         <= '0;
         id_writes_reg <= 1'b0;
         id_is_load    <= 1'b0;
         id_is_store   <= 1'b0;
         id_is_branch  <= 1'b0;
         id_is_halt    <= 1'b0;
         halted        <= 1'b0;
      end else begin
         id_valid      <= issue;
         id_writes_reg <= issue && ((dec.op_class == CLS_ALU) || (dec.op_class == CLS_LOAD));
         id_is_load    <= issue && (dec.op_class == CLS_LOAD);
         id_is_store   <= issue && (dec.op_class == CLS_STORE);
         id_is_branch  <= issue && (dec.op_class == CLS_BRANCH);
         id_is_halt    <= issue && (dec.op_class == CLS_HALT);
         if (issue) begin
            id_opcode <= dec.opcode;
            id_src1   <= dec.src1;
            id_src2   <= dec.src2;
            id_dest   <= dec.dest;
            id_rs_val <= rs_val;
            id_rt_val <= rt_val;
            id_imm    <= XLEN'($signed(dec.imm));
            id_pc     <= ifid_pc;
         end
         if (halting_now) halted <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mips_decode_stage.sv
// Bench for mips_decode_stage: directed instruction vectors, expected ID/EX
// payloads queued at issue and checked by per-DUT monitors.
module tb_mips_decode_stage;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [4:0]  src1;
      logic [4:0]  src2;
      logic [4:0]  dest;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [4:0]  flags;  // {writes_reg, is_load, is_store, is_branch, is_halt}
   } exp_t;
   localparam int W = $bits(exp_t);

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_nf_q[$];
   int n_cmp = 0;
   int n_err = 0;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        flush = 0, ex_valid = 0, ex_is_load = 0, mem_valid = 0, wb_we = 0;
   logic [4:0]  ex_dest = 0, mem_dest = 0, wb_dest = 0;
   logic [31:0] wb_data = 0;

   mips_decode_stage_if f_if();
   mips_decode_stage_if nf_if();

   logic        id_valid, id_writes_reg, id_is_load, id_is_store, id_is_branch, id_is_halt, halted;
   logic [5:0]  id_opcode;
   logic [4:0]  id_src1, id_src2, id_dest;
   logic [31:0] id_rs_val, id_rt_val, id_imm, id_pc;
   logic        nf_valid, nf_writes_reg, nf_is_load, nf_is_store, nf_is_branch, nf_is_halt, nf_halted;
   logic [5:0]  nf_opcode;
   logic [4:0]  nf_src1, nf_src2, nf_dest;
   logic [31:0] nf_rs_val, nf_rt_val, nf_imm, nf_pc;

   mips_decode_stage #(.XLEN(32), .NREG(32), .FORWARDING(1)) dut (
      .clk(clk), .rst_n(rst_n), .fetch(f_if.slave), .flush(flush),
      .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_is_load(ex_is_load),
      .mem_valid(mem_valid), .mem_dest(mem_dest),
      .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
      .id_valid(id_valid), .id_opcode(id_opcode), .id_src1(id_src1), .id_src2(id_src2),
      .id_dest(id_dest), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
      .id_pc(id_pc), .id_writes_reg(id_writes_reg), .id_is_load(id_is_load),
      .id_is_store(id_is_store), .id_is_branch(id_is_branch), .id_is_halt(id_is_halt),
      .halted(halted)
   );

   mips_decode_stage #(.XLEN(32), .NREG(32), .FORWARDING(0)) dut_nf (
      .clk(clk), .rst_n(rst_n), .fetch(nf_if.slave), .flush(flush),
      .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_is_load(ex_is_load),
      .mem_valid(mem_valid), .mem_dest(mem_dest),
      .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
      .id_valid(nf_valid), .id_opcode(nf_opcode), .id_src1(nf_src1), .id_src2(nf_src2),
      .id_dest(nf_dest), .id_rs_val(nf_rs_val), .id_rt_val(nf_rt_val), .id_imm(nf_imm),
      .id_pc(nf_pc), .id_writes_reg(nf_writes_reg), .id_is_load(nf_is_load),
      .id_is_store(nf_is_store), .id_is_branch(nf_is_branch), .id_is_halt(nf_is_halt),
      .halted(nf_halted)
   );

   // scoreboard helpers
   function automatic logic [W-1:0] mk(input logic [5:0] op, input logic [4:0] s1, s2, d,
                                       input logic [31:0] rs, rt, imm, pc,
                                       input logic [4:0] fl);
      exp_t e;
      e = '{op, s1, s2, d, rs, rt, imm, pc, fl};
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitors
   always @(negedge clk) begin
      logic [W-1:0] act, e;
      if (rst_n && id_valid) begin
         act = {id_opcode, id_src1, id_src2, id_dest, id_rs_val, id_rt_val, id_imm, id_pc,
                id_writes_reg, id_is_load, id_is_store, id_is_branch, id_is_halt};
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL fwd_unexpected_issue: got %h expected none", act);
         end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
               n_err++;
               $display("FAIL fwd_payload: got %h expected %h", act, e);
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [W-1:0] act, e;
      if (rst_n && nf_valid) begin
         act = {nf_opcode, nf_src1, nf_src2, nf_dest, nf_rs_val, nf_rt_val, nf_imm, nf_pc,
                nf_writes_reg, nf_is_load, nf_is_store, nf_is_branch, nf_is_halt};
         n_cmp++;
         if (exp_nf_q.size() == 0) begin
            n_err++;
            $display("FAIL nofwd_unexpected_issue: got %h expected none", act);
         end else begin
            e = exp_nf_q.pop_front();
            if (act !== e) begin
               n_err++;
               $display("FAIL nofwd_payload: got %h expected %h", act, e);
            end
         end
      end
   end

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   // sel[0] drives the forwarding DUT, sel[1] the non-forwarding one
   task automatic issue(input logic [1:0] sel, input logic [31:0] instr, input logic [31:0] pc);
      if (sel[0]) begin f_if.if_valid = 1'b1; f_if.if_instr = instr; f_if.if_pc = pc; end
      if (sel[1]) begin nf_if.if_valid = 1'b1; nf_if.if_instr = instr; nf_if.if_pc = pc; end
      smp();
      if (sel[0]) chk("fwd_fetch_ready", 64'(f_if.if_ready), 1);
      if (sel[1]) chk("nofwd_fetch_ready", 64'(nf_if.if_ready), 1);
      cyc();
      f_if.if_valid  = 1'b0;
      nf_if.if_valid = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      f_if.if_valid = 0;  f_if.if_instr = 0;  f_if.if_pc = 0;
      nf_if.if_valid = 0; nf_if.if_instr = 0; nf_if.if_pc = 0;

      // 1: reset, then OR R9,R5,R5 reads R5 = 0
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      smp();
      chk("reset_id_zero", 64'(|{id_valid, id_opcode, id_src1, id_src2, id_dest, id_rs_val,
                                 id_rt_val, id_imm, id_pc, id_writes_reg, id_is_load,
                                 id_is_store, id_is_branch, id_is_halt}), 0);
      chk("reset_halted", 64'(halted), 0);
      chk("reset_ready", 64'(f_if.if_ready), 1);
      chk("reset_nofwd_ready", 64'(nf_if.if_ready), 1);
      cyc();
      exp_q.push_back(mk(6'h06, 5, 5, 9, 0, 0, 32'h0000_4800, 32'h100, 5'b10000));
      issue(2'b01, 32'h18A5_4800, 32'h100);
      idle(3);

      // 2: R3 = 7, ADDI R4,R3,-2 with 2-clock latency
      wb_we = 1; wb_dest = 3; wb_data = 32'h7;
      cyc();
      wb_we = 0;
      exp_q.push_back(mk(6'h01, 3, 4, 4, 32'h7, 0, 32'hFFFF_FFFE, 32'h104, 5'b10000));
      issue(2'b01, 32'h0464_FFFE, 32'h104);
      smp();
      chk("addi_lat_1clk", 64'(id_valid), 0);
      cyc();
      smp();
      chk("addi_lat_2clk", 64'(id_valid), 1);
      cyc();
      idle(2);

      // 3a: load-use in EX stalls once
      exp_q.push_back(mk(6'h00, 2, 6, 1, 0, 0, 32'h800, 32'h108, 5'b10000));
      issue(2'b01, 32'h0046_0800, 32'h108);
      ex_valid = 1; ex_is_load = 1; ex_dest = 2;
      smp();
      chk("loaduse_stall_ready", 64'(f_if.if_ready), 0);
      cyc();
      ex_valid = 0; ex_is_load = 0; ex_dest = 0;
      smp();
      chk("loaduse_bubble", 64'(id_valid), 0);
      chk("loaduse_release_ready", 64'(f_if.if_ready), 1);
      cyc();
      smp();
      chk("loaduse_issue", 64'(id_valid), 1);
      cyc();
      idle(2);

      // 3b: non-load EX dest: forwarding DUT flows, non-forwarding DUT stalls
      exp_q.push_back(mk(6'h00, 2, 6, 1, 0, 0, 32'h800, 32'h10C, 5'b10000));
      exp_nf_q.push_back(mk(6'h00, 2, 6, 1, 0, 0, 32'h800, 32'h10C, 5'b10000));
      issue(2'b11, 32'h0046_0800, 32'h10C);
      ex_valid = 1; ex_dest = 2;
      smp();
      chk("fwd_ex_alu_ready", 64'(f_if.if_ready), 1);
      chk("nofwd_ex_stall_ready", 64'(nf_if.if_ready), 0);
      cyc();
      ex_valid = 0; ex_dest = 0;
      smp();
      chk("fwd_ex_alu_issue", 64'(id_valid), 1);
      chk("nofwd_ex_bubble", 64'(nf_valid), 0);
      cyc();
      smp();
      chk("nofwd_ex_issue", 64'(nf_valid), 1);
      cyc();
      idle(2);

      // 3c: non-forwarding DUT stalls on MEM dest
      exp_nf_q.push_back(mk(6'h00, 2, 6, 1, 0, 0, 32'h800, 32'h110, 5'b10000));
      issue(2'b10, 32'h0046_0800, 32'h110);
      mem_valid = 1; mem_dest = 2;
      smp();
      chk("nofwd_mem_stall_ready", 64'(nf_if.if_ready), 0);
      cyc();
      mem_valid = 0; mem_dest = 0;
      smp();
      chk("nofwd_mem_bubble", 64'(nf_valid), 0);
      chk("nofwd_mem_release_ready", 64'(nf_if.if_ready), 1);
      cyc();
      smp();
      chk("nofwd_mem_issue", 64'(nf_valid), 1);
      cyc();
      idle(2);

      // 4: write-first bypass of R7, and R0 write discarded
      exp_q.push_back(mk(6'h02, 7, 7, 8, 32'h1234, 32'h1234, 32'h4000, 32'h114, 5'b10000));
      issue(2'b01, 32'h08E7_4000, 32'h114);
      wb_we = 1; wb_dest = 7; wb_data = 32'h1234;
      cyc();
      wb_we = 0;
      exp_q.push_back(mk(6'h0A, 0, 7, 10, 0, 32'h1234, 32'h5000, 32'h118, 5'b10000));
      issue(2'b01, 32'h2807_5000, 32'h118);
      wb_we = 1; wb_dest = 0; wb_data = 32'hFF;
      cyc();
      wb_we = 0;
      idle(2);

      // 5: flush beats stall and a simultaneous fetch
      issue(2'b01, 32'h0046_0800, 32'h11C);
      ex_valid = 1; ex_is_load = 1; ex_dest = 2; flush = 1;
      f_if.if_valid = 1; f_if.if_instr = 32'h3467_0004; f_if.if_pc = 32'h200;
      smp();
      chk("flush_ready", 64'(f_if.if_ready), 1);
      cyc();
      flush = 0; ex_valid = 0; ex_is_load = 0; ex_dest = 0; f_if.if_valid = 0;
      smp();
      chk("flush_bubble", 64'(id_valid), 0);
      cyc();
      smp();
      chk("flush_ifid_empty", 64'(id_valid), 0);
      cyc();
      exp_q.push_back(mk(6'h0C, 0, 11, 11, 0, 0, 32'h8, 32'h120, 5'b11000));
      exp_q.push_back(mk(6'h3F, 1, 2, 2, 0, 0, 32'h1234, 32'h124, 5'b00000));
      exp_q.push_back(mk(6'h0F, 3, 7, 7, 32'h7, 32'h1234, 32'hFFFF_FFFC, 32'h128, 5'b00010));
      exp_q.push_back(mk(6'h0D, 3, 7, 7, 32'h7, 32'h1234, 32'h4, 32'h12C, 5'b00100));
      issue(2'b01, 32'h300B_0008, 32'h120);
      issue(2'b01, 32'hFC22_1234, 32'h124);
      issue(2'b01, 32'h3C67_FFFC, 32'h128);
      issue(2'b01, 32'h3467_0004, 32'h12C);
      idle(3);

      // 6: HALT then ADD; ADD never issues, reset clears halted
      exp_q.push_back(mk(6'h11, 0, 0, 0, 0, 0, 0, 32'h130, 5'b00001));
      issue(2'b01, 32'h4400_0000, 32'h130);
      f_if.if_valid = 1; f_if.if_instr = 32'h0046_0800; f_if.if_pc = 32'h134;
      cyc();
      smp();
      chk("halt_is_halt", 64'(id_is_halt), 1);
      chk("halt_halted", 64'(halted), 1);
      chk("halt_ready", 64'(f_if.if_ready), 0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         smp();
         chk("halted_ready_low", 64'(f_if.if_ready), 0);
         chk("halted_sticky", 64'(halted), 1);
      end
      cyc();
      f_if.if_valid = 0;
      rst_n = 1'b0;
      #1;
      chk("reset_async_halted", 64'(halted), 0);
      cyc();
      rst_n = 1'b1;
      smp();
      chk("post_reset_ready", 64'(f_if.if_ready), 1);
      cyc();

      // HALT squashed by a same-cycle flush
      issue(2'b01, 32'h4400_0000, 32'h140);
      flush = 1;
      smp();
      chk("halt_flush_ready", 64'(f_if.if_ready), 1);
      cyc();
      flush = 0;
      smp();
      chk("halt_flush_halted", 64'(halted), 0);
      chk("halt_flush_bubble", 64'(id_valid), 0);
      chk("halt_flush_ready_after", 64'(f_if.if_ready), 1);
      cyc();
      exp_q.push_back(mk(6'h0C, 0, 11, 11, 0, 0, 32'h8, 32'h144, 5'b11000));
      issue(2'b01, 32'h300B_0008, 32'h144);
      idle(4);

      chk("fwd_queue_drained", 64'(exp_q.size()), 0);
      chk("nofwd_queue_drained", 64'(exp_nf_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
